// File: rtl/fu_issue_arbiter.sv
// Round-robin arbiter sharing one functional unit between several issue queues.
// Grants one ready queue per cycle, registers its head entry toward the FU and tracks FU occupancy.
package fu_issue_arbiter_pkg;
    localparam int REG_ADDR_LEN = 5;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8
    } alu1_func_t;
endpackage

module fu_issue_arbiter
    import fu_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int REQ_IDX_W  = 2,
    parameter int FU_LATENCY = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req_ready,
    input  alu1_func_t [NUM_REQ-1:0]               req_insn,
    input  logic [NUM_REQ-1:0][REG_ADDR_LEN-1:0]   req_inp1,
    input  logic [NUM_REQ-1:0][REG_ADDR_LEN-1:0]   req_inp2,
    input  logic [NUM_REQ-1:0][REG_ADDR_LEN-1:0]   req_dst,
    input  logic                                   stall,
    output logic [NUM_REQ-1:0]                     issue,
    output logic                                   fu_valid,
    output alu1_func_t                             fu_insn,
    output logic [REG_ADDR_LEN-1:0]                fu_inp1,
    output logic [REG_ADDR_LEN-1:0]                fu_inp2,
    output logic [REG_ADDR_LEN-1:0]                fu_dst,
    output logic [REQ_IDX_W-1:0]                   fu_src,
    output logic                                   fu_busy
);

    if (FU_LATENCY < 1 || FU_LATENCY > 15) begin : g_bad_latency
        $error("fu_issue_arbiter: FU_LATENCY must be in 1..15");
    end

    localparam logic [3:0] BUSY_INIT = 4'(FU_LATENCY - 1);
    localparam logic [REQ_IDX_W:0] NUM_REQ_W = (REQ_IDX_W+1)'(NUM_REQ);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                busy_cnt_q, busy_cnt_d;
    logic [REQ_IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                      fu_valid_q, fu_valid_d;
    alu1_func_t                fu_insn_q, fu_insn_d;
    logic [REG_ADDR_LEN-1:0]   fu_inp1_q, fu_inp1_d;
    logic [REG_ADDR_LEN-1:0]   fu_inp2_q, fu_inp2_d;
    logic [REG_ADDR_LEN-1:0]   fu_dst_q, fu_dst_d;
    logic [REQ_IDX_W-1:0]      fu_src_q, fu_src_d;

    logic                      grant_en;
    logic                      found;
    logic [REQ_IDX_W-1:0]      sel;
    logic [REQ_IDX_W:0]        scan;

    // Scan starting at rr_ptr; the first ready queue wins.
    always_comb begin
        grant_en = !reset && !stall && (state_q == IDLE) && (|req_ready);
        found    = 1'b0;
        sel      = '0;
        scan     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (REQ_IDX_W+1)'(k);
            if (scan >= NUM_REQ_W) scan = scan - NUM_REQ_W;
            if (!found && req_ready[scan[REQ_IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = scan[REQ_IDX_W-1:0];
            end
        end
        issue = '0;
        if (grant_en) issue[sel] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        fu_valid_d = 1'b0;
        fu_insn_d  = fu_insn_q;
        fu_inp1_d  = fu_inp1_q;
        fu_inp2_d  = fu_inp2_q;
        fu_dst_d   = fu_dst_q;
        fu_src_d   = fu_src_q;

        unique case (state_q)
            IDLE: begin
                if (grant_en && FU_LATENCY > 1) begin
                    state_d    = BUSY;
                    busy_cnt_d = BUSY_INIT;
                end
            end
            BUSY: begin
                // Stall does not pause the countdown: the FU is occupied regardless.
                busy_cnt_d = busy_cnt_q - 4'd1;
                if (busy_cnt_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (grant_en) begin
            fu_valid_d = 1'b1;
            fu_insn_d  = req_insn[sel];
            fu_inp1_d  = req_inp1[sel];
            fu_inp2_d  = req_inp2[sel];
            fu_dst_d   = req_dst[sel];
            fu_src_d   = sel;
            rr_ptr_d   = (sel == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : sel + REQ_IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_cnt_q <= '0;
            rr_ptr_q   <= '0;
            fu_valid_q <= 1'b0;
            fu_insn_q  <= ALU_ADD;
            fu_inp1_q  <= '0;
            fu_inp2_q  <= '0;
            fu_dst_q   <= '0;
            fu_src_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            fu_valid_q <= fu_valid_d;
            fu_insn_q  <= fu_insn_d;
            fu_inp1_q  <= fu_inp1_d;
            fu_inp2_q  <= fu_inp2_d;
            fu_dst_q   <= fu_dst_d;
            fu_src_q   <= fu_src_d;
        end
    end

    assign fu_valid = fu_valid_q;
    assign fu_insn  = fu_insn_q;
    assign fu_inp1  = fu_inp1_q;
    assign fu_inp2  = fu_inp2_q;
    assign fu_dst   = fu_dst_q;
    assign fu_src   = fu_src_q;
    assign fu_busy  = (state_q == BUSY);

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed bench for fu_issue_arbiter: three instances (FU_LATENCY 1, 3, 4) share one stimulus.
module tb_fu_issue_arbiter;
    import fu_issue_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic [3:0] req_ready;
    alu1_func_t [3:0] req_insn;
    logic [3:0][4:0] req_inp1, req_inp2, req_dst;

    logic [3:0] issue [3];
    logic       fu_valid [3];
    alu1_func_t fu_insn [3];
    logic [4:0] fu_inp1 [3];
    logic [4:0] fu_inp2 [3];
    logic [4:0] fu_dst [3];
    logic [1:0] fu_src [3];
    logic       fu_busy [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fu_issue_arbiter #(.NUM_REQ(4), .REQ_IDX_W(2), .FU_LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .req_ready(req_ready), .req_insn(req_insn),
        .req_inp1(req_inp1), .req_inp2(req_inp2), .req_dst(req_dst), .stall(stall),
        .issue(issue[0]), .fu_valid(fu_valid[0]), .fu_insn(fu_insn[0]), .fu_inp1(fu_inp1[0]),
        .fu_inp2(fu_inp2[0]), .fu_dst(fu_dst[0]), .fu_src(fu_src[0]), .fu_busy(fu_busy[0]));

    fu_issue_arbiter #(.NUM_REQ(4), .REQ_IDX_W(2), .FU_LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset), .req_ready(req_ready), .req_insn(req_insn),
        .req_inp1(req_inp1), .req_inp2(req_inp2), .req_dst(req_dst), .stall(stall),
        .issue(issue[1]), .fu_valid(fu_valid[1]), .fu_insn(fu_insn[1]), .fu_inp1(fu_inp1[1]),
        .fu_inp2(fu_inp2[1]), .fu_dst(fu_dst[1]), .fu_src(fu_src[1]), .fu_busy(fu_busy[1]));

    fu_issue_arbiter #(.NUM_REQ(4), .REQ_IDX_W(2), .FU_LATENCY(4)) dut_l4 (
        .clk(clk), .reset(reset), .req_ready(req_ready), .req_insn(req_insn),
        .req_inp1(req_inp1), .req_inp2(req_inp2), .req_dst(req_dst), .stall(stall),
        .issue(issue[2]), .fu_valid(fu_valid[2]), .fu_insn(fu_insn[2]), .fu_inp1(fu_inp1[2]),
        .fu_inp2(fu_inp2[2]), .fu_dst(fu_dst[2]), .fu_src(fu_src[2]), .fu_busy(fu_busy[2]));

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        req_ready = 4'b0000;
        stall = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        req_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_insn[i] = ALU_XOR;
            req_inp1[i] = 5'(i + 1);
            req_inp2[i] = 5'(i + 9);
            req_dst[i]  = 5'(i + 17);
        end
        @(posedge clk); @(posedge clk); #1;
        n_chk++; if (issue[0] !== 4'b0000) begin n_fail++; $display("FAIL reset_issue got %b exp 0000", issue[0]); end
        n_chk++; if (fu_valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", fu_valid[0]); end
        n_chk++; if (fu_busy[1] !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", fu_busy[1]); end
        n_chk++; if (fu_src[0] !== 2'd0) begin n_fail++; $display("FAIL reset_src got %0d exp 0", fu_src[0]); end
        n_chk++; if (fu_insn[0] !== ALU_ADD) begin n_fail++; $display("FAIL reset_insn got %0d exp %0d", fu_insn[0], ALU_ADD); end
        n_chk++; if (fu_dst[0] !== 5'd0) begin n_fail++; $display("FAIL reset_dst got %0d exp 0", fu_dst[0]); end
    endtask

    task automatic test_single_grant();
        do_reset();
        @(posedge clk); #1;
        req_ready = 4'b0100;
        req_insn[2] = ALU_SUB;
        req_inp1[2] = 5'd4;
        req_inp2[2] = 5'd5;
        req_dst[2]  = 5'd6;
        #1;
        n_chk++; if (issue[0] !== 4'b0100) begin n_fail++; $display("FAIL single_issue got %b exp 0100", issue[0]); end
        @(posedge clk); #1;
        req_ready = 4'b0000;
        n_chk++; if (fu_valid[0] !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", fu_valid[0]); end
        n_chk++; if (fu_src[0] !== 2'd2) begin n_fail++; $display("FAIL single_src got %0d exp 2", fu_src[0]); end
        n_chk++; if (fu_insn[0] !== ALU_SUB) begin n_fail++; $display("FAIL single_insn got %0d exp %0d", fu_insn[0], ALU_SUB); end
        n_chk++; if (fu_inp1[0] !== 5'd4) begin n_fail++; $display("FAIL single_inp1 got %0d exp 4", fu_inp1[0]); end
        n_chk++; if (fu_inp2[0] !== 5'd5) begin n_fail++; $display("FAIL single_inp2 got %0d exp 5", fu_inp2[0]); end
        n_chk++; if (fu_dst[0] !== 5'd6) begin n_fail++; $display("FAIL single_dst got %0d exp 6", fu_dst[0]); end
        @(posedge clk); #1;
        n_chk++; if (fu_valid[0] !== 1'b0) begin n_fail++; $display("FAIL single_pulse got %b exp 0", fu_valid[0]); end
        n_chk++; if (fu_dst[0] !== 5'd6) begin n_fail++; $display("FAIL single_hold_dst got %0d exp 6", fu_dst[0]); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_iss [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_src [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c > 0) begin
                n_chk++; if (fu_valid[0] !== 1'b1) begin n_fail++; $display("FAIL rr_valid c%0d got %b exp 1", c, fu_valid[0]); end
                n_chk++; if (fu_src[0] !== exp_src[c-1]) begin n_fail++; $display("FAIL rr_src c%0d got %0d exp %0d", c, fu_src[0], exp_src[c-1]); end
            end
            if (c < 5) begin
                req_ready = 4'b1111;
                #1;
                n_chk++; if (issue[0] !== exp_iss[c]) begin n_fail++; $display("FAIL rr_issue c%0d got %b exp %b", c, issue[0], exp_iss[c]); end
            end else begin
                req_ready = 4'b0000;
            end
        end
    endtask

    task automatic test_busy_latency();
        logic [3:0] exp_iss [7]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0100};
        logic       exp_busy [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       exp_vld [7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            n_chk++; if (fu_busy[1] !== exp_busy[c]) begin n_fail++; $display("FAIL l3_busy c%0d got %b exp %b", c, fu_busy[1], exp_busy[c]); end
            n_chk++; if (fu_valid[1] !== exp_vld[c]) begin n_fail++; $display("FAIL l3_valid c%0d got %b exp %b", c, fu_valid[1], exp_vld[c]); end
            req_ready = 4'b1111;
            #1;
            n_chk++; if (issue[1] !== exp_iss[c]) begin n_fail++; $display("FAIL l3_issue c%0d got %b exp %b", c, issue[1], exp_iss[c]); end
        end
        @(posedge clk); #1;
        req_ready = 4'b0000;
        n_chk++; if (fu_src[1] !== 2'd2) begin n_fail++; $display("FAIL l3_src got %0d exp 2", fu_src[1]); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req_ready = 4'b0011;
            stall = 1'b1;
            #1;
            n_chk++; if (issue[0] !== 4'b0000) begin n_fail++; $display("FAIL stall_issue c%0d got %b exp 0000", c, issue[0]); end
            n_chk++; if (fu_valid[0] !== 1'b0) begin n_fail++; $display("FAIL stall_valid c%0d got %b exp 0", c, fu_valid[0]); end
        end
        @(posedge clk); #1;
        stall = 1'b0;
        #1;
        n_chk++; if (issue[0] !== 4'b0001) begin n_fail++; $display("FAIL unstall_issue0 got %b exp 0001", issue[0]); end
        @(posedge clk); #1;
        n_chk++; if (fu_src[0] !== 2'd0) begin n_fail++; $display("FAIL unstall_src0 got %0d exp 0", fu_src[0]); end
        #1;
        n_chk++; if (issue[0] !== 4'b0010) begin n_fail++; $display("FAIL unstall_issue1 got %b exp 0010", issue[0]); end
        @(posedge clk); #1;
        req_ready = 4'b0000;
        n_chk++; if (fu_src[0] !== 2'd1) begin n_fail++; $display("FAIL unstall_src1 got %0d exp 1", fu_src[0]); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        @(posedge clk); #1;
        req_ready = 4'b0100;
        #1;
        n_chk++; if (issue[2] !== 4'b0100) begin n_fail++; $display("FAIL midrst_grant got %b exp 0100", issue[2]); end
        @(posedge clk); #1;
        req_ready = 4'b0000;
        n_chk++; if (fu_busy[2] !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b exp 1", fu_busy[2]); end
        reset = 1'b1;
        #1;
        n_chk++; if (fu_busy[2] !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", fu_busy[2]); end
        n_chk++; if (fu_valid[2] !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", fu_valid[2]); end
        reset = 1'b0;
        req_ready = 4'b0101;
        #1;
        n_chk++; if (issue[2] !== 4'b0001) begin n_fail++; $display("FAIL midrst_first got %b exp 0001", issue[2]); end
        @(posedge clk); #1;
        n_chk++; if (fu_src[2] !== 2'd0) begin n_fail++; $display("FAIL midrst_src got %0d exp 0", fu_src[2]); end
        n_chk++; if (fu_busy[2] !== 1'b1) begin n_fail++; $display("FAIL midrst_rebusy got %b exp 1", fu_busy[2]); end
        req_ready = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_busy_latency();
        test_stall();
        test_reset_mid_op();
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
